// File: rtl/regfile_arbiter_if.sv
// Requester-side bus of regfile_arbiter: packed per-requester ops in, one-hot grant and read data out.
// The lock vector exists only when REGFILE_ARB_LOCK_EN is defined.
interface regfile_arbiter_if #(
    parameter int unsigned NREQ = 3
);
    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   we;
    logic [3*NREQ-1:0] src_a;
    logic [3*NREQ-1:0] src_b;
    logic [3*NREQ-1:0] dest;
    logic [8*NREQ-1:0] wdata;
`ifdef REGFILE_ARB_LOCK_EN
    logic [NREQ-1:0]   lock;
`endif
    logic [NREQ-1:0]   gnt;
    logic [7:0]        rdata_a;
    logic [7:0]        rdata_b;

`ifdef REGFILE_ARB_LOCK_EN
    modport master (output req, we, src_a, src_b, dest, wdata, lock,
                    input  gnt, rdata_a, rdata_b);
    modport slave  (input  req, we, src_a, src_b, dest, wdata, lock,
                    output gnt, rdata_a, rdata_b);
`else
    modport master (output req, we, src_a, src_b, dest, wdata,
                    input  gnt, rdata_a, rdata_b);
    modport slave  (input  req, we, src_a, src_b, dest, wdata,
                    output gnt, rdata_a, rdata_b);
`endif
endinterface

// File: rtl/regfile_arbiter.sv
// Round-robin arbiter sharing the 8x8 register file among NREQ requesters, one grant per cycle.
// Optional burst lock (lock port, lock_cnt) is built when REGFILE_ARB_LOCK_EN is defined.
module regfile_arbiter #(
    parameter int unsigned NREQ     = 3,
    parameter int unsigned MAX_LOCK = 4
) (
    input  logic             clk,
    input  logic             reset,
    regfile_arbiter_if.slave bus,
    output logic             rf_ld,
    output logic [2:0]       rf_src_a,
    output logic [2:0]       rf_src_b,
    output logic [2:0]       rf_dest,
    output logic [7:0]       rf_data_d,
    input  logic [7:0]       rf_data_a,
    input  logic [7:0]       rf_data_b
);
    localparam int unsigned PW = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 4) begin : g_bad_nreq
        $error("regfile_arbiter: NREQ must be 2..4");
    end
    if (MAX_LOCK < 2 || MAX_LOCK > 15) begin : g_bad_max_lock
        $error("regfile_arbiter: MAX_LOCK must be 2..15");
    end

    // (base + off) mod NREQ for requester indices
    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int unsigned off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= NREQ) sum = sum - NREQ;
        return PW'(sum);
    endfunction

    logic [NREQ-1:0] gnt_q;
    logic [NREQ-1:0] gnt_d;
    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   rr_d;
    logic [NREQ-1:0] eligible;
    logic [PW-1:0]   win;
    logic [PW-1:0]   idx;
    logic            found;

    // Round-robin search starting at rr_ptr; a requester holding the grant is skipped
    always_comb begin
        eligible = bus.req & ~gnt_q;
        found    = 1'b0;
        win      = '0;
        idx      = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = wrap_add(rr_ptr, k);
            if (!found && eligible[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

`ifdef REGFILE_ARB_LOCK_EN
    localparam int unsigned CW = 4;

    logic [CW-1:0] lock_cnt;
    logic [CW-1:0] cnt_d;
    logic [PW-1:0] gidx;

    always_comb begin
        gidx = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt_q[i]) gidx = PW'(i);
        end
    end

    // lock_cnt holds grants already given in the current burst, so the MAX_LOCK-th grant releases
    always_comb begin
        gnt_d = '0;
        rr_d  = rr_ptr;
        cnt_d = '0;
        if (found) begin
            gnt_d[win] = 1'b1;
            rr_d       = wrap_add(win, 1);
        end
        if ((|(gnt_q & bus.req & bus.lock)) && (32'(lock_cnt) + 32'd1 < MAX_LOCK)) begin
            gnt_d = gnt_q;
            rr_d  = wrap_add(gidx, 1);
            cnt_d = lock_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gnt_q    <= '0;
            rr_ptr   <= '0;
            lock_cnt <= '0;
        end else begin
            gnt_q    <= gnt_d;
            rr_ptr   <= rr_d;
            lock_cnt <= cnt_d;
        end
    end
`else
    always_comb begin
        gnt_d = '0;
        rr_d  = rr_ptr;
        if (found) begin
            gnt_d[win] = 1'b1;
            rr_d       = wrap_add(win, 1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gnt_q  <= '0;
            rr_ptr <= '0;
        end else begin
            gnt_q  <= gnt_d;
            rr_ptr <= rr_d;
        end
    end
`endif

    assign bus.gnt = gnt_q;

    // Register file port steered from the granted requester; follows gnt_q so reset drops rf_ld at once
    always_comb begin
        rf_ld       = |(gnt_q & bus.we);
        rf_src_a    = '0;
        rf_src_b    = '0;
        rf_dest     = '0;
        rf_data_d   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt_q[i]) begin
                rf_src_a  = bus.src_a[3*i +: 3];
                rf_src_b  = bus.src_b[3*i +: 3];
                rf_dest   = bus.dest[3*i +: 3];
                rf_data_d = bus.wdata[8*i +: 8];
            end
        end
        bus.rdata_a = (|gnt_q) ? rf_data_a : 8'h00;
        bus.rdata_b = (|gnt_q) ? rf_data_b : 8'h00;
    end
endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter with a behavioural 8x8 register file; lock scenario runs
// only when REGFILE_ARB_LOCK_EN is defined.
module tb_regfile_arbiter;
    localparam logic [8:0] A_SA = {3'd6, 3'd3, 3'd0};
    localparam logic [8:0] A_SB = {3'd7, 3'd4, 3'd1};

    logic       clk;
    logic       reset;
    logic       rf_ld;
    logic [2:0] rf_src_a, rf_src_b, rf_dest;
    logic [7:0] rf_data_d, rf_data_a, rf_data_b;
    logic [7:0] rf [8] = '{8'h0F, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16};

    regfile_arbiter_if #(.NREQ(3)) bus ();

    regfile_arbiter #(.NREQ(3), .MAX_LOCK(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .rf_ld     (rf_ld),
        .rf_src_a  (rf_src_a),
        .rf_src_b  (rf_src_b),
        .rf_dest   (rf_dest),
        .rf_data_d (rf_data_d),
        .rf_data_a (rf_data_a),
        .rf_data_b (rf_data_b)
    );

    assign rf_data_a = rf[rf_src_a];
    assign rf_data_b = rf[rf_src_b];
    always @(posedge clk) if (rf_ld) rf[rf_dest] <= rf_data_d;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [2:0]  req, we;
        logic [8:0]  sa, sb, dst;
        logic [23:0] wd;
        logic [2:0]  e_gnt;
        logic        e_ld;
        logic [2:0]  e_sa, e_sb, e_dst;
        logic [7:0]  e_wd, e_ra, e_rb;
    } vec_t;

    vec_t vecs[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [2:0] req, input logic [2:0] we, input logic [8:0] sa,
                       input logic [8:0] sb, input logic [8:0] dst, input logic [23:0] wd,
                       input logic [2:0] eg, input logic el, input logic [2:0] esa,
                       input logic [2:0] esb, input logic [2:0] edst, input logic [7:0] ewd,
                       input logic [7:0] era, input logic [7:0] erb);
        vec_t v;
        v.req = req; v.we = we; v.sa = sa; v.sb = sb; v.dst = dst; v.wd = wd;
        v.e_gnt = eg; v.e_ld = el; v.e_sa = esa; v.e_sb = esb; v.e_dst = edst;
        v.e_wd = ewd; v.e_ra = era; v.e_rb = erb;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic [2:0] req, input logic [2:0] we, input logic [8:0] sa,
                         input logic [8:0] sb, input logic [8:0] dst, input logic [23:0] wd);
        bus.req = req; bus.we = we; bus.src_a = sa; bus.src_b = sb;
        bus.dest = dst; bus.wdata = wd;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".gnt"},     32'(bus.gnt),     32'd0);
        chk({tag, ".rf_ld"},   32'(rf_ld),       32'd0);
        chk({tag, ".rf_src_a"},32'(rf_src_a),    32'd0);
        chk({tag, ".rf_src_b"},32'(rf_src_b),    32'd0);
        chk({tag, ".rf_dest"}, 32'(rf_dest),     32'd0);
        chk({tag, ".rf_data_d"},32'(rf_data_d),  32'd0);
        chk({tag, ".rdata_a"}, 32'(bus.rdata_a), 32'd0);
        chk({tag, ".rdata_b"}, 32'(bus.rdata_b), 32'd0);
    endtask

    initial begin
        reset = 1'b0;
        drive(3'b111, 3'b000, A_SA, A_SB, 9'd0, 24'd0);
`ifdef REGFILE_ARB_LOCK_EN
        bus.lock = 3'b000;
`endif
        // Rotation with all requesting, then drop
        add(3'b111, 3'b000, A_SA, A_SB, 9'd0, 24'd0, 3'b001, 1'b0, 3'd0, 3'd1, 3'd0, 8'h00, 8'h0F, 8'h10);
        add(3'b111, 3'b000, A_SA, A_SB, 9'd0, 24'd0, 3'b010, 1'b0, 3'd3, 3'd4, 3'd0, 8'h00, 8'h12, 8'h13);
        add(3'b111, 3'b000, A_SA, A_SB, 9'd0, 24'd0, 3'b100, 1'b0, 3'd6, 3'd7, 3'd0, 8'h00, 8'h15, 8'h16);
        add(3'b111, 3'b000, A_SA, A_SB, 9'd0, 24'd0, 3'b001, 1'b0, 3'd0, 3'd1, 3'd0, 8'h00, 8'h0F, 8'h10);
        add(3'b111, 3'b000, A_SA, A_SB, 9'd0, 24'd0, 3'b010, 1'b0, 3'd3, 3'd4, 3'd0, 8'h00, 8'h12, 8'h13);
        add(3'b000, 3'b000, A_SA, A_SB, 9'd0, 24'd0, 3'b100, 1'b0, 3'd6, 3'd7, 3'd0, 8'h00, 8'h15, 8'h16);
        // Requester 1 writes A7 to r5, then reads it back
        add(3'b010, 3'b010, {3'd6, 3'd5, 3'd0}, {3'd7, 3'd4, 3'd1}, {3'd0, 3'd5, 3'd0},
            {8'h00, 8'hA7, 8'h00}, 3'b000, 1'b0, 3'd0, 3'd0, 3'd0, 8'h00, 8'h00, 8'h00);
        add(3'b010, 3'b010, {3'd6, 3'd5, 3'd0}, {3'd7, 3'd4, 3'd1}, {3'd0, 3'd5, 3'd0},
            {8'h00, 8'hA7, 8'h00}, 3'b010, 1'b1, 3'd5, 3'd4, 3'd5, 8'hA7, 8'h14, 8'h13);
        add(3'b010, 3'b000, {3'd6, 3'd5, 3'd0}, {3'd7, 3'd2, 3'd1}, 9'd0, 24'd0,
            3'b000, 1'b0, 3'd0, 3'd0, 3'd0, 8'h00, 8'h00, 8'h00);
        add(3'b010, 3'b000, {3'd6, 3'd5, 3'd0}, {3'd7, 3'd2, 3'd1}, 9'd0, 24'd0,
            3'b010, 1'b0, 3'd5, 3'd2, 3'd0, 8'h00, 8'hA7, 8'h11);
        // Requester 2 writes 22 to r2 reading r2 (old 11); requester 0 then reads 22
        add(3'b101, 3'b100, {3'd2, 3'd0, 3'd2}, {3'd3, 3'd0, 3'd6}, {3'd2, 3'd0, 3'd0},
            {8'h22, 8'h00, 8'h00}, 3'b000, 1'b0, 3'd0, 3'd0, 3'd0, 8'h00, 8'h00, 8'h00);
        add(3'b101, 3'b100, {3'd2, 3'd0, 3'd2}, {3'd3, 3'd0, 3'd6}, {3'd2, 3'd0, 3'd0},
            {8'h22, 8'h00, 8'h00}, 3'b100, 1'b1, 3'd2, 3'd3, 3'd2, 8'h22, 8'h11, 8'h12);
        add(3'b001, 3'b100, {3'd2, 3'd0, 3'd2}, {3'd3, 3'd0, 3'd6}, {3'd2, 3'd0, 3'd0},
            {8'h22, 8'h00, 8'h00}, 3'b001, 1'b0, 3'd2, 3'd6, 3'd0, 8'h00, 8'h22, 8'h15);
        add(3'b000, 3'b000, 9'd0, 9'd0, 9'd0, 24'd0,
            3'b000, 1'b0, 3'd0, 3'd0, 3'd0, 8'h00, 8'h00, 8'h00);

        repeat (2) @(negedge clk);
        chk_idle("reset");
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            drive(vecs[i].req, vecs[i].we, vecs[i].sa, vecs[i].sb, vecs[i].dst, vecs[i].wd);
            @(negedge clk);
            chk($sformatf("v%0d.gnt", i),       32'(bus.gnt),     32'(vecs[i].e_gnt));
            chk($sformatf("v%0d.rf_ld", i),     32'(rf_ld),       32'(vecs[i].e_ld));
            chk($sformatf("v%0d.rf_src_a", i),  32'(rf_src_a),    32'(vecs[i].e_sa));
            chk($sformatf("v%0d.rf_src_b", i),  32'(rf_src_b),    32'(vecs[i].e_sb));
            chk($sformatf("v%0d.rf_dest", i),   32'(rf_dest),     32'(vecs[i].e_dst));
            chk($sformatf("v%0d.rf_data_d", i), 32'(rf_data_d),   32'(vecs[i].e_wd));
            chk($sformatf("v%0d.rdata_a", i),   32'(bus.rdata_a), 32'(vecs[i].e_ra));
            chk($sformatf("v%0d.rdata_b", i),   32'(bus.rdata_b), 32'(vecs[i].e_rb));
        end

        // Reset in the middle of a write grant must abort the write
        @(posedge clk);
        #1;
        drive(3'b010, 3'b010, 9'd0, 9'd0, {3'd0, 3'd7, 3'd0}, {8'h00, 8'h5A, 8'h00});
        @(posedge clk);
        #2;
        chk("rstw.gnt_before",  32'(bus.gnt), 32'b010);
        chk("rstw.ld_before",   32'(rf_ld),   32'd1);
        chk("rstw.dest_before", 32'(rf_dest), 32'd7);
        reset = 1'b0;
        #1;
        chk("rstw.ld_after",    32'(rf_ld),     32'd0);
        chk("rstw.gnt_after",   32'(bus.gnt),   32'd0);
        chk("rstw.dest_after",  32'(rf_dest),   32'd0);
        chk("rstw.data_after",  32'(rf_data_d), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("rstw.r7_kept", 32'(rf[7]), 32'h16);
        drive(3'b000, 3'b000, 9'd0, 9'd0, 9'd0, 24'd0);
        reset = 1'b1;

`ifdef REGFILE_ARB_LOCK_EN
        // Requester 0 locked against requester 2: four grants to 0, then 2
        @(posedge clk);
        #1;
        drive(3'b101, 3'b000, A_SA, A_SB, 9'd0, 24'd0);
        bus.lock = 3'b001;
        @(negedge clk);
        chk("lock.idle", 32'(bus.gnt), 32'd0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("lock.burst%0d", c), 32'(bus.gnt), 32'b001);
        end
        @(negedge clk);
        chk("lock.release", 32'(bus.gnt), 32'b100);
        chk("lock.release_rdata", 32'(bus.rdata_a), 32'h15);
        drive(3'b000, 3'b000, 9'd0, 9'd0, 9'd0, 24'd0);
        bus.lock = 3'b000;
        @(negedge clk);
        chk("lock.done", 32'(bus.gnt), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_arbiter.md
# regfile_arbiter

Round-robin arbiter sharing the 8×8 game-state register file between up to four requesters: input handler, game logic, display scanner and so on. Each requester presents one read-pair or write operation. The arbiter grants one requester per cycle, drives the register file address/data/load lines from the granted requester, and returns the read data alongside the grant pulse. It sits between the requesters and the register file and is the only block that drives the register file's load and address inputs.

## Interface
Parameters:
- NREQ, 3, number of requesters; legal range 2..4.
- MAX_LOCK, 4, maximum consecutive grants to one locked requester; legal range 2..15. Used only with the lock feature.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset: asserts immediately, deasserts synchronously to clk.
- req  in  NREQ  per-requester request; must be held until gnt.
- we  in  NREQ  per-requester op: 1 = write, 0 = read.
- src_a  in  3*NREQ  read address A, packed; requester i uses bits [3i+2:3i].
- src_b  in  3*NREQ  read address B, packed the same way.
- dest  in  3*NREQ  write address, packed the same way.
- wdata  in  8*NREQ  write data; requester i uses bits [8i+7:8i].
- lock  in  NREQ  burst-lock request; present only with REGFILE_ARB_LOCK_EN.
- gnt  out  NREQ  one-hot grant, registered.
- rdata_a  out  8  register A data; valid only in a cycle where gnt is nonzero.
- rdata_b  out  8  register B data; valid only in a cycle where gnt is nonzero.
- rf_ld  out  1  register file load.
- rf_src_a  out  3  register file read address A.
- rf_src_b  out  3  register file read address B.
- rf_dest  out  3  register file write address.
- rf_data_d  out  8  register file write data.
- rf_data_a  in  8  register file read port A (combinational).
- rf_data_b  in  8  register file read port B (combinational).

## Operation
- State: gnt_q (one-hot or zero), rr_ptr (index with highest priority), lock_cnt (4 bits, only with the lock feature).
- Arbitration each cycle:
  - eligible = req & ~gnt_q. A requester's req is ignored in the same cycle it holds a grant, so every requester is granted at most every other cycle unless locked.
  - Winner is the first eligible index searching rr_ptr, rr_ptr+1, … modulo NREQ.
  - Next-cycle values: gnt_q ← one-hot(winner), or zero if nothing is eligible. rr_ptr ← (winner+1) mod NREQ on any grant, otherwise unchanged.
- Grant cycle, with requester g granted:
  - rf_src_a/rf_src_b/rf_dest/rf_data_d = requester g's fields.
  - rf_ld = we[g].
  - rdata_a = rf_data_a and rdata_b = rf_data_b.
- No-grant cycle: rf_ld=0, all rf_* address/data outputs = 0, rdata_a/rdata_b = 0.
- A write commits on the clock edge that ends the grant cycle.
- A write op still returns rdata for src_a/src_b. The data is the pre-write value, including when src equals dest.
- Requester obligations:
  - Hold req and all fields stable from assertion until the cycle gnt[i] is seen high.
  - Deassert req, or present a new op, in the following cycle.
  - Dropping req before grant is legal. The op is abandoned, and a grant already registered for it still executes.
- Reset (reset=0): gnt_q=0, rr_ptr=0, lock_cnt=0. Therefore rf_ld=0, every rf_* output = 0 and rdata_a/rdata_b = 0. Reset mid-grant aborts the write immediately: rf_ld falls asynchronously and no register file update occurs.

## Timing
- Latency: req rising before edge T gives gnt high in the cycle after edge T (one cycle) when uncontended.
- Throughput: one op per cycle overall. An uncontended single requester gets 50% throughput, or 100% with lock.
- Read-after-write: a read granted in the cycle after the write grant sees the new value.
- gnt is exactly one cycle per op; gnt is never more than one-hot.
- All requesters continuously requesting: grants rotate 0,1,2,0,… with no starvation. Worst-case wait is NREQ−1 grant cycles.

## Configuration
- REGFILE_ARB_LOCK_EN defined:
  - The lock port exists.
  - If granted requester g has lock[g]=1 and req[g]=1, g is re-granted next cycle, bypassing eligibility and rr_ptr.
  - lock_cnt counts consecutive grants. On the MAX_LOCK-th consecutive grant, the lock is forcibly released: the next cycle arbitrates normally with g excluded, and lock_cnt clears.
  - lock_cnt clears on any grant without lock, and in idle cycles.
- REGFILE_ARB_LOCK_EN undefined: no lock port and no lock_cnt; arbitration is pure round-robin as above.

## Test plan
- Reset with all req high → gnt=0, rf_ld=0, rf_* outputs=0. First grant after release goes to requester 0.
- Requester 1 writes dest=5 wdata=8'hA7; requester 1 then reads src_a=5 → gnt[1] pulse with rf_ld=1; the later read returns rdata_a=8'hA7.
- req=3'b111 held for 6 cycles → gnt sequence 001,010,100,001,010,100, with no gaps.
- Same-cycle write with dest=src_a=2 (old value 8'h11, wdata 8'h22) → rdata_a=8'h11; the next read of register 2 returns 8'h22.
- reset asserted in a write grant cycle → rf_ld drops immediately; the target register is unchanged.
- With REGFILE_ARB_LOCK_EN, MAX_LOCK=4: requester 0 locked while requester 2 requests → gnt[0] on 4 consecutive cycles, then gnt[2].
